// File: rtl/vga_timing_pipe.sv
// VGA/DVI raster generator; oRequest leads the pins by REQ_LEAD+1 clocks, no backpressure (source must keep up).
// Optional VGA_TEST_PATTERN_EN adds iPatSel to substitute bars/checker/solid colour at the input-colour point.
module vga_timing_pipe #(
  parameter int DW       = 8,
  parameter int H_ACT    = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACT    = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int REQ_LEAD = 2
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iEN,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
`ifdef VGA_TEST_PATTERN_EN
  input  logic [1:0]    iPatSel,
`endif
  output logic          oRequest,
  output logic [11:0]   oX,
  output logic [11:0]   oY,
  output logic          oLineStart,
  output logic          oFrameStart,
  output logic [DW-1:0] oVGA_R,
  output logic [DW-1:0] oVGA_G,
  output logic [DW-1:0] oVGA_B,
  output logic          oVGA_H_SYNC,
  output logic          oVGA_V_SYNC,
  output logic          oVGA_BLANK,
  output logic          oVGA_SYNC
);

  localparam logic [11:0] H_ACT_W = 12'(H_ACT);
  localparam logic [11:0] H_SS    = 12'(H_ACT + H_FRONT);
  localparam logic [11:0] H_SE    = 12'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [11:0] H_LAST  = 12'(H_ACT + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [11:0] V_ACT_W = 12'(V_ACT);
  localparam logic [11:0] V_SS    = 12'(V_ACT + V_FRONT);
  localparam logic [11:0] V_SE    = 12'(V_ACT + V_FRONT + V_SYNC);
  localparam logic [11:0] V_LAST  = 12'(V_ACT + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic        HP      = 1'(H_POL);
  localparam logic        VP      = 1'(V_POL);

`ifdef VGA_TEST_PATTERN_EN
  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [11:0] y;
  } ent_t;
`else
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } ent_t;
`endif

  logic [11:0] hc, vc;
  logic        run;
  ent_t        cur, tap;

  // run is iEN as seen at the last edge; the first enabled cycle shows (0,0) before counting starts.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hc  <= '0;
      vc  <= '0;
      run <= 1'b0;
    end else begin
      run <= iEN;
      if (!iEN) begin
        hc <= '0;
        vc <= '0;
      end else if (run) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? 12'd0 : vc + 12'd1;
        end else begin
          hc <= hc + 12'd1;
        end
      end
    end
  end

  always_comb begin
    cur     = '0;
    cur.act = run && (hc < H_ACT_W) && (vc < V_ACT_W);
    cur.hs  = run && (hc >= H_SS) && (hc < H_SE);
    cur.vs  = run && (vc >= V_SS) && (vc < V_SE);
`ifdef VGA_TEST_PATTERN_EN
    cur.x   = hc;
    cur.y   = vc;
`endif
  end

  assign oRequest    = cur.act;
  assign oX          = hc;
  assign oY          = vc;
  assign oLineStart  = run && (hc == 12'd0);
  assign oFrameStart = run && (hc == 12'd0) && (vc == 12'd0);
  assign oVGA_SYNC   = 1'b0;

  generate
    if (REQ_LEAD == 0) begin : g_nolead
      assign tap = cur;
    end else begin : g_lead
      ent_t sr [REQ_LEAD];
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          for (int i = 0; i < REQ_LEAD; i++) sr[i] <= '0;
        end else begin
          sr[0] <= cur;
          for (int i = 1; i < REQ_LEAD; i++) sr[i] <= sr[i-1];
        end
      end
      assign tap = sr[REQ_LEAD-1];
    end
  endgenerate

  logic [DW-1:0] r_src, g_src, b_src;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
  logic [11:0] bar;
  logic [2:0]  bi;
  assign bar = tap.x / 12'(BAR_W);
  assign bi  = (bar > 12'd7) ? 3'd7 : bar[2:0];

  // Bar order W,Y,C,G,M,R,B,K falls out of inverted index bits.
  always_comb begin
    r_src = iRed;
    g_src = iGreen;
    b_src = iBlue;
    case (iPatSel)
      2'd1: begin
        r_src = {DW{~bi[1]}};
        g_src = {DW{~bi[2]}};
        b_src = {DW{~bi[0]}};
      end
      2'd2: begin
        r_src = {DW{tap.x[4] ^ tap.y[4]}};
        g_src = {DW{tap.x[4] ^ tap.y[4]}};
        b_src = {DW{tap.x[4] ^ tap.y[4]}};
      end
      2'd3: begin
        r_src = {DW{1'b1}};
        g_src = {DW{1'b1}};
        b_src = {DW{1'b1}};
      end
      default: ;
    endcase
  end
`else
  assign r_src = iRed;
  assign g_src = iGreen;
  assign b_src = iBlue;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oVGA_R      <= '0;
      oVGA_G      <= '0;
      oVGA_B      <= '0;
      oVGA_BLANK  <= 1'b0;
      oVGA_H_SYNC <= ~HP;
      oVGA_V_SYNC <= ~VP;
    end else begin
      oVGA_R      <= tap.act ? r_src : '0;
      oVGA_G      <= tap.act ? g_src : '0;
      oVGA_B      <= tap.act ? b_src : '0;
      oVGA_BLANK  <= tap.act;
      oVGA_H_SYNC <= tap.hs ? HP : ~HP;
      oVGA_V_SYNC <= tap.vs ? VP : ~VP;
    end
  end

endmodule
